// File: rtl/deinterleaver_top.sv
// Block deinterleaver with two ping-pong banks.
// Bits arrive in interleaved order (index j). Each bit is written to bank[kj],
// where kj is the interleaver permutation of j. Bits leave in natural order
// (index k). One bank fills while the other drains, which sustains
// 1 bit/cycle once the first symbol is complete.
module deinterleaver_top #(
   parameter int Ncbps = 192,        // coded bits per symbol (block size)
   parameter int Ncpc  = 2,          // coded bits per carrier
   parameter int s     = Ncpc / 2,   // second-permutation modulus
   parameter int d     = 16          // interleaver column count
) (
   input  logic clk,
   input  logic resetN,
   input  logic data_in,
   input  logic valid_in,
   output logic ready_out,
   output logic data_out,
   output logic valid_out,
   input  logic ready_in
);

   localparam int AW = (Ncbps > 1) ? $clog2(Ncbps) : 1;
   localparam logic [AW-1:0] IDX_LAST = AW'(Ncbps - 1);

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_st_e;

   // Destination of interleaved bit j. Intermediates are 32 bits wide so
   // that d*j and d*m never wrap before the divisions.
   function automatic logic [AW-1:0] perm_k(input logic [AW-1:0] j);
      logic [31:0] jw;
      logic [31:0] mw;
      logic [31:0] tw;
      jw = 32'(j);
      mw = 32'(s) * (jw / 32'(s)) + ((jw + (32'(d) * jw) / 32'(Ncbps)) % 32'(s));
      tw = 32'(d) * mw;
      return AW'(tw - 32'(Ncbps - 1) * (tw / 32'(Ncbps)));
   endfunction

   // A bank accepts writes while it is empty or partially filled.
   function automatic logic bank_writable(input bank_st_e st);
      logic w;
      case (st)
         BANK_EMPTY, BANK_FILLING: w = 1'b1;
         BANK_FULL, BANK_DRAINING: w = 1'b0;
         default:                  w = 1'b0;
      endcase
      return w;
   endfunction

   // A bank is readable once it holds a complete symbol.
   function automatic logic bank_readable(input bank_st_e st);
      logic r;
      case (st)
         BANK_FULL, BANK_DRAINING: r = 1'b1;
         BANK_EMPTY, BANK_FILLING: r = 1'b0;
         default:                  r = 1'b0;
      endcase
      return r;
   endfunction

   bank_st_e          bank_st_q [2];
   bank_st_e          bank_st_d [2];
   logic              wr_sel_q, wr_sel_d;
   logic              rd_sel_q, rd_sel_d;
   logic [AW-1:0]     j_q, j_d;
   logic [AW-1:0]     k_q, k_d;
   logic [Ncbps-1:0]  bank_q [2];

   logic              wr_fire_s;
   logic              rd_fire_s;
   logic [AW-1:0]     kj_s;

   // Handshake outputs decoded straight from the bank state registers.
   always_comb begin
      ready_out = bank_writable(bank_st_q[wr_sel_q]);
      valid_out = bank_readable(bank_st_q[rd_sel_q]);
      if (valid_out) begin
         data_out = bank_q[rd_sel_q][k_q];
      end else begin
         data_out = 1'b0;
      end
      wr_fire_s = valid_in && ready_out;
      rd_fire_s = valid_out && ready_in;
      kj_s      = perm_k(j_q);
   end

   // Bank FSMs, write/read indices and bank selects: next-state logic.
   // Write and read never target the same bank in one cycle because a bank
   // cannot be writable and readable at the same time.
   always_comb begin
      bank_st_d = bank_st_q;
      wr_sel_d  = wr_sel_q;
      rd_sel_d  = rd_sel_q;
      j_d       = j_q;
      k_d       = k_q;
      if (wr_fire_s) begin
         if (j_q == IDX_LAST) begin
            bank_st_d[wr_sel_q] = BANK_FULL;
            j_d                 = '0;
            wr_sel_d            = ~wr_sel_q;
         end else begin
            bank_st_d[wr_sel_q] = BANK_FILLING;
            j_d                 = j_q + AW'(1);
         end
      end else begin
         j_d = j_q;
      end
      if (rd_fire_s) begin
         if (k_q == IDX_LAST) begin
            bank_st_d[rd_sel_q] = BANK_EMPTY;
            k_d                 = '0;
            rd_sel_d            = ~rd_sel_q;
         end else begin
            bank_st_d[rd_sel_q] = BANK_DRAINING;
            k_d                 = k_q + AW'(1);
         end
      end else begin
         k_d = k_q;
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         bank_st_q[0] <= BANK_EMPTY;
         bank_st_q[1] <= BANK_EMPTY;
         wr_sel_q     <= 1'b0;
         rd_sel_q     <= 1'b0;
         j_q          <= '0;
         k_q          <= '0;
      end else begin
         bank_st_q <= bank_st_d;
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         j_q       <= j_d;
         k_q       <= k_d;
      end
   end

   // Bank storage: accepted bit lands at its deinterleaved position.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         bank_q[0] <= '0;
         bank_q[1] <= '0;
      end else if (wr_fire_s) begin
         bank_q[wr_sel_q][kj_s] <= data_in;
      end
   end

endmodule

// File: doc/deinterleaver_top.md
DEINTERLEAVER_TOP -- requirements
Module: deinterleaver_top

Interface
REQ-001 SHALL have parameter Ncbps, default 192, coded bits per symbol (block size).
REQ-002 SHALL have parameter Ncpc, default 2, coded bits per carrier (2 = QPSK, 4 = 16QAM, 6 = 64QAM).
REQ-003 SHALL have parameter s, default Ncpc/2, second-permutation modulus.
REQ-004 SHALL have parameter d, default 16, interleaver column count; Ncbps SHALL be a multiple of d.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port resetN, input, 1, synchronous active-low reset.
REQ-007 SHALL have port data_in, input, 1, interleaved bit, position j of the received symbol.
REQ-008 SHALL have port valid_in, input, 1, upstream asserts that data_in is valid.
REQ-009 SHALL have port ready_out, output, 1, block can accept a bit this cycle.
REQ-010 SHALL have port data_out, output, 1, deinterleaved bit, position k in natural order.
REQ-011 SHALL have port valid_out, output, 1, data_out is valid.
REQ-012 SHALL have port ready_in, input, 1, downstream can accept data_out this cycle.

Function
REQ-013 SHALL accept an input bit on every clk edge where valid_in && ready_out, and retire an output bit on every edge where valid_out && ready_in.
REQ-014 SHALL use two Ncbps-bit banks (ping-pong); each bank has state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
REQ-015 SHALL count write index j from 0 to Ncbps-1 and store an accepted bit j at bank[kj], where mj = s*floor(j/s) + (j + floor(d*j/Ncbps)) mod s and kj = d*mj - (Ncbps-1)*floor(d*mj/Ncbps).
REQ-016 SHALL, for s=1, produce kj = d*(j mod (Ncbps/d)) + floor(j/(Ncbps/d)); e.g. j=0->0, j=1->16, j=11->176, j=12->1, j=191->191.
REQ-017 SHALL compute kj in log2(Ncbps) bits with no truncation of intermediates; kj SHALL always be < Ncbps.
REQ-018 SHALL mark the write bank FULL on the edge that accepts j=Ncbps-1, then reset j to 0 and switch writing to the other bank.
REQ-019 SHALL drive ready_out = 1 only while the current write bank is EMPTY or FILLING; ready_out SHALL be 0 while both banks are FULL or DRAINING.
REQ-020 SHALL drive valid_out = 1 only while the current read bank is FULL or DRAINING, with data_out = readbank[k] for read index k (0..Ncbps-1).
REQ-021 SHALL advance k on each output transfer; on transfer of k=Ncbps-1 it SHALL mark the bank EMPTY, reset k to 0 and switch reading to the other bank.
REQ-022 SHALL give first-bit latency: valid_out rises on the cycle after the edge accepting j=Ncbps-1 (no earlier).
REQ-023 SHALL, when the last read of bank A and the last write of bank B occur on the same edge, free A and fill B together; the next cycle has ready_out=1 (write to A) and valid_out=1 (read from B).
REQ-024 SHALL sustain 1 bit/cycle throughput with valid_in and ready_in held high: no ready_out deassertion after the first symbol.
REQ-025 SHALL hold data_out stable and keep k unchanged while valid_out && !ready_in (backpressure).
REQ-026 SHALL ignore data_in and hold j while valid_in=0.

Reset
REQ-027 SHALL, when resetN=0 at a clk edge, set both banks EMPTY, j=0, k=0, write and read bank select to bank 0, valid_out=0, data_out=0, and ready_out=1 from the first cycle after reset release.
REQ-028 SHALL, on reset mid-symbol, discard all partial and full bank contents; the first symbol after reset SHALL be written starting at j=0.

Verification
REQ-029 SHALL pass with Ncbps=192, Ncpc=2, d=16, fed MSB-first 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E -> output collected MSB-first equals 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA.
REQ-030 SHALL pass with the same vector fed for 5 back-to-back symbols, valid_in=ready_in=1 -> 5 identical outputs matching REQ-029, ready_out never 0 after cycle 0, first valid_out on cycle 192.
REQ-031 SHALL pass with ready_in=0 held for 400 cycles after the first symbol -> ready_out falls after the 384th accepted bit, data_out frozen, and no bits lost once ready_in=1.
REQ-032 SHALL pass with valid_in toggled pseudo-randomly -> output identical to REQ-029, with j not advancing on valid_in=0 cycles.
REQ-033 SHALL pass with resetN pulsed low after 100 input bits -> valid_out=0, and the next full symbol reproduces the REQ-029 output.
REQ-034 SHALL pass a round-trip with interleaver_top feeding deinterleaver_top on random data for Ncpc in {2,4,6} -> output equals the interleaver input bit-for-bit.
